// File: rtl/axis_acc_pkg.sv
// Shared types and helpers for the nibble-word accumulator: FSM states, keep rules, lane sizing.
package axis_acc_pkg;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } acc_state_t;

  localparam int KEEP_STEP = 4;
  localparam int KEEP_W    = 8;

  function automatic int lane_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // A keep value is a non-zero bit count in whole nibbles that fits one input word
  function automatic logic keep_legal(input logic [KEEP_W-1:0] keep, input int in_w);
    return (int'(keep) != 0) && ((int'(keep) % KEEP_STEP) == 0) && (int'(keep) <= in_w);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// One-entry skid buffer: upstream ready comes straight from a flop, stalled words park in buf_r.
module axis_skid_buffer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         areset,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] buf_r;
  logic         full_r;
  logic         rdy_r;

  // Park an accepted word when downstream stalls; release it once downstream takes it
  always_ff @(posedge clk) begin
    if (areset) begin
      buf_r  <= '0;
      full_r <= 1'b0;
      rdy_r  <= 1'b0;
    end else if (full_r) begin
      if (m_ready) begin
        full_r <= 1'b0;
        rdy_r  <= 1'b1;
      end else begin
        full_r <= 1'b1;
        rdy_r  <= 1'b0;
      end
    end else if (s_valid && rdy_r && !m_ready) begin
      buf_r  <= s_data;
      full_r <= 1'b1;
      rdy_r  <= 1'b0;
    end else begin
      rdy_r  <= 1'b1;
    end
  end

  assign s_ready = rdy_r;
  assign m_valid = full_r || (s_valid && rdy_r);
  assign m_data  = full_r ? buf_r : s_data;

endmodule

// File: rtl/axis_nibble_word_accumulator.sv
// Packs RATIO packed IN_W-bit AXI-Stream words into one OUT_W beat, flushing partial beats on tlast.
// Define AXIS_ACC_SKID_EN to put a one-entry skid buffer (registered s_axis_tready) on the input.
module axis_nibble_word_accumulator
  import axis_acc_pkg::*;
#(
  parameter  int IN_W  = 16,
  parameter  int RATIO = 4,
  localparam int OUT_W = IN_W * RATIO
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [7:0]       s_axis_tkeep,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [7:0]       m_axis_tkeep,
  output logic             err_keep
);

  localparam int LANE_W = lane_width(RATIO);

  logic [IN_W-1:0]   in_data_s;
  logic [7:0]        in_keep_s;
  logic              in_last_s;
  logic              in_valid_s;
  logic              in_ready_s;

  acc_state_t        state_r;
  logic [LANE_W-1:0] lane_r;
  logic [OUT_W-1:0]  accum_r;
  logic [7:0]        bits_r;
  logic              pend_last_r;
  logic [OUT_W-1:0]  out_data_r;
  logic [7:0]        out_keep_r;
  logic              out_last_r;
  logic              out_valid_r;
  logic              err_r;

`ifdef AXIS_ACC_SKID_EN
  logic [IN_W+8:0] skid_in_s;
  logic [IN_W+8:0] skid_out_s;

  assign skid_in_s = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  axis_skid_buffer #(
    .W (IN_W + 9)
  ) u_skid (
    .clk     (clk),
    .areset  (areset),
    .s_data  (skid_in_s),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (skid_out_s),
    .m_valid (in_valid_s),
    .m_ready (in_ready_s)
  );

  assign {in_last_s, in_keep_s, in_data_s} = skid_out_s;
`else
  assign in_data_s     = s_axis_tdata;
  assign in_keep_s     = s_axis_tkeep;
  assign in_last_s     = s_axis_tlast;
  assign in_valid_s    = s_axis_tvalid;
  assign s_axis_tready = in_ready_s;
`endif

  logic              accept_s;
  logic              close_s;
  logic              m_hs_s;
  logic              out_free_s;
  logic              legal_s;
  logic              bad_s;
  logic [7:0]        eff_keep_s;
  logic [IN_W-1:0]   mask_s;
  logic [IN_W-1:0]   masked_s;
  logic [OUT_W-1:0]  accum_next_s;
  logic [7:0]        bits_next_s;

  assign in_ready_s = (state_r == FILL) && !areset;
  assign accept_s   = in_valid_s && in_ready_s;
  assign close_s    = (int'(lane_r) == (RATIO - 1)) || in_last_s;
  assign m_hs_s     = out_valid_r && m_axis_tready;
  assign out_free_s = !out_valid_r || m_axis_tready;

  // Classify the incoming keep, mask the word and merge it into its lane of the accumulator
  always_comb begin
    legal_s    = keep_legal(in_keep_s, IN_W);
    bad_s      = !legal_s || ((int'(in_keep_s) < IN_W) && !in_last_s);
    eff_keep_s = bad_s ? 8'(IN_W) : in_keep_s;
    mask_s     = '0;
    for (int b = 0; b < IN_W; b++) begin
      mask_s[b] = (b < int'(in_keep_s));
    end
    masked_s     = legal_s ? (in_data_s & mask_s) : in_data_s;
    accum_next_s = accum_r;
    accum_next_s[int'(lane_r)*IN_W +: IN_W] = masked_s;
    bits_next_s  = bits_r + eff_keep_s;
  end

  // FILL/WAIT controller with the registered output beat
  always_ff @(posedge clk) begin
    if (areset) begin
      state_r     <= FILL;
      lane_r      <= '0;
      accum_r     <= '0;
      bits_r      <= 8'd0;
      pend_last_r <= 1'b0;
      out_data_r  <= '0;
      out_keep_r  <= 8'd0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r <= accept_s && bad_s;
      case (state_r)
        FILL: begin
          if (m_hs_s) begin
            out_valid_r <= 1'b0;
          end
          if (accept_s) begin
            if (close_s && out_free_s) begin
              // drain and reload on the same edge, so back-to-back beats have no bubble
              out_data_r  <= accum_next_s;
              out_keep_r  <= bits_next_s;
              out_last_r  <= in_last_s;
              out_valid_r <= 1'b1;
              accum_r     <= '0;
              bits_r      <= 8'd0;
              lane_r      <= '0;
            end else if (close_s) begin
              accum_r     <= accum_next_s;
              bits_r      <= bits_next_s;
              pend_last_r <= in_last_s;
              lane_r      <= '0;
              state_r     <= WAIT;
            end else begin
              accum_r     <= accum_next_s;
              bits_r      <= bits_next_s;
              lane_r      <= lane_r + LANE_W'(1);
            end
          end
        end
        WAIT: begin
          if (m_hs_s) begin
            out_data_r  <= accum_r;
            out_keep_r  <= bits_r;
            out_last_r  <= pend_last_r;
            out_valid_r <= 1'b1;
            accum_r     <= '0;
            bits_r      <= 8'd0;
            state_r     <= FILL;
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

  assign m_axis_tdata  = out_data_r;
  assign m_axis_tkeep  = out_keep_r;
  assign m_axis_tlast  = out_last_r;
  assign m_axis_tvalid = out_valid_r;
  assign err_keep      = err_r;

endmodule
